// File: rtl/lb_pkg.sv
// Local-bus shared definitions: initiator FSM state encoding and
// default bus widths used by the master and the lb_* register slaves.
package lb_pkg;

    localparam int LB_DATA_WDTH_DFLT = 32;
    localparam int LB_ADDR_WDTH_DFLT = 32;

    typedef enum logic [1:0] {
        LB_IDLE = 2'd0,
        LB_REQ  = 2'd1,
        LB_WAIT = 2'd2,
        LB_RSP  = 2'd3
    } lb_state_e;

endpackage

// File: rtl/lb_sat_cnt.sv
// Saturating statistic counter with synchronous clear (clear beats increment).
// Ports: lb_clk, lb_rst_n (async low), clr, inc, cnt[W-1:0].
module lb_sat_cnt #(
    parameter int W = 32
)(
    input  logic         lb_clk,
    input  logic         lb_rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] ONE = W'(1);

    always_ff @(posedge lb_clk or negedge lb_rst_n) begin
        if (!lb_rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/lb_master_ctrl.sv
// Local-bus initiator: one command in, one lb_wreq/lb_rreq out, waits for
// the matching ack or a timeout, returns one response, keeps statistics.
// Ports: lb_clk, lb_rst_n; cmd_* (valid/ready command in); rsp_* (valid/ready
// response out); lb_w*/lb_r* (local-bus strobes, address, data, acks);
// cnt_clr and stat_wr_cnt/stat_rd_cnt/stat_to_cnt (saturating statistics).
module lb_master_ctrl
    import lb_pkg::*;
#(
    parameter int LB_DATA_WDTH = LB_DATA_WDTH_DFLT,
    parameter int LB_ADDR_WDTH = LB_ADDR_WDTH_DFLT,
    parameter int TIMEOUT_CYC  = 256,
    parameter int DGBCNT_WDTH  = 32
)(
    input  logic                    lb_clk,
    input  logic                    lb_rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_wr,
    input  logic [LB_ADDR_WDTH-1:0] cmd_addr,
    input  logic [LB_DATA_WDTH-1:0] cmd_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [LB_DATA_WDTH-1:0] rsp_rdata,
    output logic                    rsp_err,
    output logic                    lb_wreq,
    output logic [LB_ADDR_WDTH-1:0] lb_waddr,
    output logic [LB_DATA_WDTH-1:0] lb_wdata,
    input  logic                    lb_wack,
    output logic                    lb_rreq,
    output logic [LB_ADDR_WDTH-1:0] lb_raddr,
    input  logic [LB_DATA_WDTH-1:0] lb_rdata,
    input  logic                    lb_rack,
    input  logic                    cnt_clr,
    output logic [DGBCNT_WDTH-1:0]  stat_wr_cnt,
    output logic [DGBCNT_WDTH-1:0]  stat_rd_cnt,
    output logic [DGBCNT_WDTH-1:0]  stat_to_cnt
);

    // Timeout fires when the WAIT counter is about to reach this value,
    // so a response appears TIMEOUT_CYC cycles after the REQ cycle.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    lb_state_e state_q, state_d;

    logic        wr_q;
    logic [15:0] to_cnt_q;

    logic ack_hit, to_hit, accept;
    logic wr_done, rd_done, to_done;

    logic                    cmd_ready_d, rsp_valid_d, rsp_err_d;
    logic                    lb_wreq_d, lb_rreq_d;
    logic [LB_DATA_WDTH-1:0] rsp_rdata_d;

    // Only the ack matching the issued strobe counts.
    always_comb begin
        ack_hit = wr_q ? lb_wack : lb_rack;
        to_hit  = (to_cnt_q + 16'd1) == TO_LAST;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LB_IDLE: if (cmd_valid)          state_d = LB_REQ;
            LB_REQ:                          state_d = LB_WAIT;
            LB_WAIT: if (ack_hit || to_hit)  state_d = LB_RSP;
            LB_RSP:  if (rsp_ready)          state_d = LB_IDLE;
            default:                         state_d = LB_IDLE;
        endcase
    end

    always_comb begin
        accept  = (state_q == LB_IDLE) && cmd_valid;
        wr_done = (state_q == LB_WAIT) && wr_q && lb_wack;
        rd_done = (state_q == LB_WAIT) && !wr_q && lb_rack;
        to_done = (state_q == LB_WAIT) && !ack_hit && to_hit;

        cmd_ready_d = (state_d == LB_IDLE);
        rsp_valid_d = (state_d == LB_RSP);
        lb_wreq_d   = accept && cmd_wr;
        lb_rreq_d   = accept && !cmd_wr;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;

        unique case (1'b1)
            wr_done: begin
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
            end
            rd_done: begin
                rsp_rdata_d = lb_rdata;
                rsp_err_d   = 1'b0;
            end
            to_done: begin
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b1;
            end
            default: ;
        endcase
    end

    // cmd_ready comes out of reset high so a command can be taken
    // in the very first cycle.
    always_ff @(posedge lb_clk or negedge lb_rst_n) begin
        if (!lb_rst_n) begin
            state_q   <= LB_IDLE;
            wr_q      <= 1'b0;
            to_cnt_q  <= '0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            lb_wreq   <= 1'b0;
            lb_rreq   <= 1'b0;
            lb_waddr  <= '0;
            lb_raddr  <= '0;
            lb_wdata  <= '0;
        end else begin
            state_q   <= state_d;
            cmd_ready <= cmd_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            lb_wreq   <= lb_wreq_d;
            lb_rreq   <= lb_rreq_d;
            if (accept) begin
                wr_q     <= cmd_wr;
                lb_waddr <= cmd_addr;
                lb_raddr <= cmd_addr;
                lb_wdata <= cmd_wdata;
            end
            if (state_q == LB_REQ) begin
                to_cnt_q <= '0;
            end else if (state_q == LB_WAIT) begin
                to_cnt_q <= to_cnt_q + 16'd1;
            end
        end
    end

    lb_sat_cnt #(.W(DGBCNT_WDTH)) u_wr_cnt (
        .lb_clk   (lb_clk),
        .lb_rst_n (lb_rst_n),
        .clr      (cnt_clr),
        .inc      (wr_done),
        .cnt      (stat_wr_cnt)
    );

    lb_sat_cnt #(.W(DGBCNT_WDTH)) u_rd_cnt (
        .lb_clk   (lb_clk),
        .lb_rst_n (lb_rst_n),
        .clr      (cnt_clr),
        .inc      (rd_done),
        .cnt      (stat_rd_cnt)
    );

    lb_sat_cnt #(.W(DGBCNT_WDTH)) u_to_cnt (
        .lb_clk   (lb_clk),
        .lb_rst_n (lb_rst_n),
        .clr      (cnt_clr),
        .inc      (to_done),
        .cnt      (stat_to_cnt)
    );

endmodule

// File: tb/tb_lb_master_ctrl.sv
// Directed bench for lb_master_ctrl: table of single transactions against
// a programmable-latency slave, plus stall, reset and counter sequences.
module tb_lb_master_ctrl;

    logic        lb_clk = 1'b0;
    logic        lb_rst_n;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        lb_wreq, lb_rreq, lb_wack, lb_rack;
    logic [31:0] lb_waddr, lb_raddr, lb_wdata, lb_rdata;
    logic        cnt_clr;
    logic [3:0]  stat_wr_cnt, stat_rd_cnt, stat_to_cnt;

    always #5 lb_clk = ~lb_clk;

    lb_master_ctrl #(
        .LB_DATA_WDTH (32),
        .LB_ADDR_WDTH (32),
        .TIMEOUT_CYC  (16),
        .DGBCNT_WDTH  (4)
    ) dut (
        .lb_clk      (lb_clk),
        .lb_rst_n    (lb_rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_wr      (cmd_wr),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .lb_wreq     (lb_wreq),
        .lb_waddr    (lb_waddr),
        .lb_wdata    (lb_wdata),
        .lb_wack     (lb_wack),
        .lb_rreq     (lb_rreq),
        .lb_raddr    (lb_raddr),
        .lb_rdata    (lb_rdata),
        .lb_rack     (lb_rack),
        .cnt_clr     (cnt_clr),
        .stat_wr_cnt (stat_wr_cnt),
        .stat_rd_cnt (stat_rd_cnt),
        .stat_to_cnt (stat_to_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int m_wr = 0, m_rd = 0, m_to = 0;

    // Slave model: acks sl_dly cycles after the strobe cycle (0 = never);
    // sl_wrong answers with the opposite ack type.
    int          sl_dly = 0;
    bit          sl_wrong = 1'b0;
    logic [31:0] sl_rdata = '0;
    int          k = 0;
    bit          pend_wr = 1'b0;
    int          n_wreq = 0, n_rreq = 0, n_both = 0, n_strobe = 0;
    logic [31:0] st_waddr = '0, st_raddr = '0, st_wdata = '0;

    initial begin
        lb_wack  = 1'b0;
        lb_rack  = 1'b0;
        lb_rdata = '0;
    end

    always @(negedge lb_clk) begin
        lb_wack  = 1'b0;
        lb_rack  = 1'b0;
        lb_rdata = '0;
        if (k > 0) begin
            k = k - 1;
            if (k == 0) begin
                if (pend_wr ^ sl_wrong) begin
                    lb_wack = 1'b1;
                end else begin
                    lb_rack  = 1'b1;
                    lb_rdata = sl_rdata;
                end
            end
        end
        if (lb_wreq || lb_rreq) begin
            n_strobe = n_strobe + 1;
            if (lb_wreq) n_wreq = n_wreq + 1;
            if (lb_rreq) n_rreq = n_rreq + 1;
            if (lb_wreq && lb_rreq) n_both = n_both + 1;
            st_waddr = lb_waddr;
            st_raddr = lb_raddr;
            st_wdata = lb_wdata;
            pend_wr  = lb_wreq;
            k        = sl_dly;
        end
    end

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          dly;
        bit          wrong;
        logic [31:0] sdata;
        int          lat;
        logic [31:0] rdata;
        bit          err;
    } vec_t;

    vec_t tbl[9];

    task automatic tick();
        @(negedge lb_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic sat_inc(inout int c);
        if (c < 15) c++;
    endtask

    task automatic chk_stats(input string nm);
        chk({nm, " stat_wr"}, 32'(stat_wr_cnt), 32'(m_wr));
        chk({nm, " stat_rd"}, 32'(stat_rd_cnt), 32'(m_rd));
        chk({nm, " stat_to"}, 32'(stat_to_cnt), 32'(m_to));
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic wait_ready(input string nm);
        int b;
        b = 0;
        while (!cmd_ready && b < 50) begin
            tick();
            b++;
        end
        chk({nm, " cmd_ready wait"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        int lat, w0, r0;
        wait_ready(nm);
        sl_dly    = v.dly;
        sl_wrong  = v.wrong;
        sl_rdata  = v.sdata;
        w0        = n_wreq;
        r0        = n_rreq;
        rsp_ready = 1'b1;
        cmd_wr    = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        wait_rsp(lat);
        chk({nm, " latency"}, 32'(lat), 32'(v.lat));
        chk({nm, " rsp_rdata"}, rsp_rdata, v.rdata);
        chk({nm, " rsp_err"}, 32'(rsp_err), 32'(v.err));
        chk({nm, " wreq cycles"}, 32'(n_wreq - w0), v.wr ? 32'd1 : 32'd0);
        chk({nm, " rreq cycles"}, 32'(n_rreq - r0), v.wr ? 32'd0 : 32'd1);
        chk({nm, " both strobes"}, 32'(n_both), 32'd0);
        chk({nm, " strobe addr"}, v.wr ? st_waddr : st_raddr, v.addr);
        if (v.wr) chk({nm, " strobe wdata"}, st_wdata, v.wdata);
        if (v.err) sat_inc(m_to);
        else if (v.wr) sat_inc(m_wr);
        else sat_inc(m_rd);
        tick();
        chk({nm, " rsp_valid drop"}, 32'(rsp_valid), 32'd0);
        chk({nm, " cmd_ready back"}, 32'(cmd_ready), 32'd1);
        repeat (3) tick();
        chk_stats(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, s0;
        bit bad;
        vec_t wv;

        tbl[0] = '{1'b1, 32'h0004_0040, 32'h1234_5678, 1,  1'b0,
                   32'h0,         3,  32'h0,         1'b0};
        tbl[1] = '{1'b0, 32'h0004_0000, 32'h0,         1,  1'b0,
                   32'h2023_0310, 3,  32'h2023_0310, 1'b0};
        tbl[2] = '{1'b0, 32'h0005_0000, 32'h0,         0,  1'b0,
                   32'hDEAD_BEEF, 17, 32'h0,         1'b1};
        tbl[3] = '{1'b0, 32'h0004_0008, 32'h0,         15, 1'b0,
                   32'hCAFE_F00D, 17, 32'hCAFE_F00D, 1'b0};
        tbl[4] = '{1'b1, 32'h0004_0010, 32'hA5A5_A5A5, 16, 1'b0,
                   32'h0,         17, 32'h0,         1'b1};
        tbl[5] = '{1'b1, 32'h0004_0014, 32'h0000_0001, 1,  1'b1,
                   32'h5555_AAAA, 17, 32'h0,         1'b1};
        tbl[6] = '{1'b0, 32'h0004_0018, 32'h0,         1,  1'b1,
                   32'h7777_0000, 17, 32'h0,         1'b1};
        tbl[7] = '{1'b1, 32'h0004_001C, 32'h0BAD_F00D, 4,  1'b0,
                   32'h0,         6,  32'h0,         1'b0};
        tbl[8] = '{1'b0, 32'h0004_0024, 32'h0,         2,  1'b0,
                   32'hFFFF_FFFF, 4,  32'hFFFF_FFFF, 1'b0};

        lb_rst_n  = 1'b0;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        cnt_clr   = 1'b0;
        repeat (3) tick();
        lb_rst_n = 1'b1;
        tick();

        chk("reset cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        chk("reset strobes", 32'({lb_wreq, lb_rreq}), 32'd0);
        chk("reset lb_waddr", lb_waddr, 32'h0);
        chk("reset lb_wdata", lb_wdata, 32'h0);
        chk_stats("reset");

        for (int i = 0; i < 9; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // Response stalled for 5 cycles while a second command waits.
        wait_ready("stall");
        sl_dly    = 1;
        sl_wrong  = 1'b0;
        sl_rdata  = 32'h1111_2222;
        rsp_ready = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = 32'h0004_0020;
        cmd_valid = 1'b1;
        tick();
        wait_rsp(lat);
        chk("stall first latency", 32'(lat), 32'd3);
        s0 = n_strobe;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("stall%0d rsp_rdata", i), rsp_rdata, 32'h1111_2222);
            chk($sformatf("stall%0d cmd_ready", i), 32'(cmd_ready), 32'd0);
            chk($sformatf("stall%0d strobes", i), 32'(n_strobe - s0), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        sl_rdata  = 32'h3333_4444;
        tick();
        chk("stall release rsp_valid", 32'(rsp_valid), 32'd0);
        chk("stall release cmd_ready", 32'(cmd_ready), 32'd1);
        chk("stall release strobes", 32'(n_strobe - s0), 32'd0);
        tick();
        cmd_valid = 1'b0;
        chk("stall second strobe", 32'(lb_rreq), 32'd1);
        wait_rsp(lat);
        chk("stall second latency", 32'(lat), 32'd3);
        chk("stall second rdata", rsp_rdata, 32'h3333_4444);
        m_rd = m_rd + 2;
        tick();
        chk_stats("stall");

        // Reset mid-WAIT; the slave's late ack then lands in IDLE.
        wait_ready("rst");
        sl_dly    = 8;
        sl_rdata  = 32'h9999_0000;
        cmd_wr    = 1'b0;
        cmd_addr  = 32'h0004_0030;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (4) tick();
        lb_rst_n = 1'b0;
        #1;
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst lb_raddr", lb_raddr, 32'h0);
        m_wr = 0;
        m_rd = 0;
        m_to = 0;
        chk_stats("rst");
        tick();
        lb_rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (rsp_valid || !cmd_ready || lb_rreq || lb_wreq) bad = 1'b1;
        end
        chk("rst quiet after late ack", 32'(bad), 32'd0);
        chk_stats("rst after");

        // Saturate the write counter, then clear it.
        wv = '{1'b1, 32'h0004_0040, 32'h0000_00AA, 1, 1'b0,
               32'h0, 3, 32'h0, 1'b0};
        for (int i = 0; i < 16; i++) begin
            run_vec($sformatf("sat%0d", i), wv);
        end
        chk("sat value", 32'(stat_wr_cnt), 32'd15);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        m_wr = 0;
        m_rd = 0;
        m_to = 0;
        chk_stats("clr");
        run_vec("post clr", wv);

        // Clear coincident with an increment.
        wait_ready("clr inc");
        sl_dly    = 1;
        cmd_wr    = 1'b1;
        cmd_addr  = 32'h0004_0044;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        m_wr = 0;
        chk("clr inc rsp_valid", 32'(rsp_valid), 32'd1);
        chk("clr inc stat_wr", 32'(stat_wr_cnt), 32'd0);
        tick();
        chk("clr inc cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (2) tick();
        chk_stats("clr inc");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lb_master_ctrl.md
Name: lb_master_ctrl

Overview:
Local-bus initiator that turns single-beat commands from an upstream command port into lb_wreq/lb_rreq transactions toward the local-bus register slaves (for example the CDMA config block).
- Waits for the matching lb_wack/lb_rack, or times out on unmapped addresses.
- Returns one response per command (read data plus error flag) and keeps saturating transaction statistics.
- Sits between the PCIe/host command path and all lb_* slaves.

Parameters:
- LB_DATA_WDTH, 32, local-bus data width.
- LB_ADDR_WDTH, 32, local-bus address width.
- TIMEOUT_CYC, 256, cycles waited in WAIT before a timeout error; legal range 2..65535.
- DGBCNT_WDTH, 32, width of statistic counters.

Ports:
- lb_clk  in  1  local-bus clock
- lb_rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_wr  in  1  1=write, 0=read
- cmd_addr  in  LB_ADDR_WDTH  byte address
- cmd_wdata  in  LB_DATA_WDTH  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_rdata  out  LB_DATA_WDTH  read data; 0 for writes and errors
- rsp_err  out  1  1=timeout
- lb_wreq  out  1  write strobe, one cycle
- lb_waddr  out  LB_ADDR_WDTH  address
- lb_wdata  out  LB_DATA_WDTH  write data
- lb_wack  in  1  write acknowledge
- lb_rreq  out  1  read strobe, one cycle
- lb_raddr  out  LB_ADDR_WDTH  address
- lb_rdata  in  LB_DATA_WDTH  read data, valid with lb_rack
- lb_rack  in  1  read acknowledge
- cnt_clr  in  1  synchronous clear of statistic counters
- stat_wr_cnt  out  DGBCNT_WDTH  completed writes (acked)
- stat_rd_cnt  out  DGBCNT_WDTH  completed reads (acked)
- stat_to_cnt  out  DGBCNT_WDTH  timeouts

Behaviour:
- Reset: all state and outputs are asynchronously cleared. State=IDLE. cmd_ready=1 the first cycle after reset deasserts; rsp_valid, rsp_err, lb_wreq and lb_rreq are 0; addr, data and counters are 0.
- Reset mid-transaction aborts without a response. A late ack arriving after reset is ignored in IDLE.
- FSM IDLE -> REQ -> WAIT -> RSP -> IDLE, all outputs registered.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: capture cmd_wr/addr/wdata, cmd_ready<=0, go to REQ.
- REQ (exactly 1 cycle):
  - lb_wreq=cmd_wr, lb_rreq=!cmd_wr.
  - Never both strobes; the strobe is never longer than one cycle.
  - Go to WAIT and clear the timeout counter.
- WAIT:
  - Counter increments each cycle.
  - Write with lb_wack=1 -> RSP, rsp_err=0, rsp_rdata=0.
  - Read with lb_rack=1 -> RSP, rsp_rdata<=lb_rdata, rsp_err=0.
  - An ack of the wrong type is ignored.
  - When the counter reaches TIMEOUT_CYC-1 with no ack -> RSP, rsp_err=1, rsp_rdata=0.
  - Ack and timeout in the same cycle: the ack wins.
- lb_waddr and lb_raddr both carry the captured address, and lb_wdata the captured data, from REQ until leaving WAIT. Both addresses hold their last value otherwise.
- RSP:
  - rsp_valid=1; rsp fields are stable until rsp_ready.
  - On rsp_ready: rsp_valid<=0, go to IDLE.
  - Acks arriving in RSP or IDLE are ignored.
- Latency with a 1-cycle-ack slave:
  - cmd accepted at cycle N.
  - Strobe at N+1, ack at N+2.
  - rsp_valid at N+3.
  - Next cmd_ready at N+4 if rsp_ready was high at N+3.
- Throughput: one outstanding transaction; no pipelining.
- Counters: increment on the transition into RSP (write ack, read ack, timeout respectively). They saturate at all-ones. cnt_clr zeroes them; a clear in the same cycle as an increment wins.

Decomposition:
- Package lb_pkg: state encoding (IDLE/REQ/WAIT/RSP) and the LB_DATA_WDTH/LB_ADDR_WDTH defaults, shared with the lb slaves.
- One sub-module, lb_sat_cnt: a saturating counter with clear and increment, instantiated three times.

Test Plan:
- Write 0x0004_0040 data 0x1234_5678 to a 1-cycle-ack slave -> lb_wreq for exactly 1 cycle, rsp_valid 3 cycles after accept, rsp_err=0, stat_wr_cnt=1.
- Read 0x0004_0000 from a slave returning 0x2023_0310 -> rsp_rdata=0x2023_0310, rsp_err=0, stat_rd_cnt=1.
- Read unmapped 0x0005_0000 with TIMEOUT_CYC=16 -> rsp_valid 16 cycles after REQ, rsp_err=1, rsp_rdata=0, stat_to_cnt=1.
- Ack driven on exactly the timeout cycle -> rsp_err=0 and data taken. A spurious lb_rack during a write -> ignored, and the transaction times out.
- rsp_ready held low 5 cycles -> rsp fields stable, cmd_ready=0, no new lb strobes. cmd_valid held high throughout is accepted only after the response handshake.
- lb_rst_n pulsed low mid-WAIT -> immediate IDLE, no rsp_valid, counters 0. A later cnt_clr pulse during a saturated stat_wr_cnt (DGBCNT_WDTH=4 at 15) -> value 0.
